// File: rtl/acq_trigger_scheduler.sv
// Acquisition sequencer for the waveform recorder: pretrigger fill, circular armed recording,
// first-edge trigger capture, post-trigger recording, then stop with trigger address/source.
module acq_trigger_scheduler #(
   parameter int ADDR_WIDTH   = 14,
   parameter int SOURCE_COUNT = 4
) (
   input  logic                    sysClk,
   input  logic                    sysReset,
   input  logic                    sysArm,
   input  logic                    sysAbort,
   input  logic [SOURCE_COUNT-1:0] sysTriggerEnables,
   input  logic [SOURCE_COUNT-1:0] sysTriggers,
   input  logic [ADDR_WIDTH-1:0]   sysPretrigger,
   input  logic [ADDR_WIDTH-1:0]   sysAcqLength,
   input  logic                    sampleValid,
   output logic                    wrEnable,
   output logic [ADDR_WIDTH-1:0]   wrAddress,
   output logic [ADDR_WIDTH-1:0]   triggerAddress,
   output logic [SOURCE_COUNT-1:0] triggerSource,
   output logic                    busy,
   output logic                    done,
   output logic                    donePulse,
   output logic [2:0]              debugState
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state;
   logic [SOURCE_COUNT-1:0] history;
   logic [SOURCE_COUNT-1:0] events;
   logic [SOURCE_COUNT-1:0] winner;
   logic [ADDR_WIDTH-1:0]   wrPtr;
   logic [ADDR_WIDTH-1:0]   preCount;
   logic [ADDR_WIDTH-1:0]   postLength;
   logic [ADDR_WIDTH-1:0]   postCount;
   logic                    triggerPending;
   logic [ADDR_WIDTH:0]     lengthDiff;
   logic [ADDR_WIDTH-1:0]   postInit;
   logic                    writeNow;

   assign events = sysTriggers & ~history & sysTriggerEnables;

   // Scan from the top so the lowest-index event overwrites the others.
   always_comb begin
      winner = '0;
      for (int i = SOURCE_COUNT - 1; i >= 0; i--) begin
         if (events[i]) begin
            winner    = '0;
            winner[i] = 1'b1;
         end
      end
   end

   // A pretrigger at or beyond the length still records the trigger sample itself.
   assign lengthDiff = {1'b0, sysAcqLength} - {1'b0, sysPretrigger};
   assign postInit   = (lengthDiff[ADDR_WIDTH] || (lengthDiff == '0)) ? ADDR_ONE
                                                                      : lengthDiff[ADDR_WIDTH-1:0];

   assign writeNow = sampleValid && !sysAbort &&
                     ((state == FILL) || (state == ARMED) ||
                      ((state == POST) && (postCount != '0)));

   assign busy       = (state == FILL) || (state == ARMED) || (state == POST);
   assign debugState = state;

   always_ff @(posedge sysClk or posedge sysReset) begin
      if (sysReset) begin
         state          <= IDLE;
         history        <= '1;
         wrPtr          <= '0;
         preCount       <= '0;
         postLength     <= '0;
         postCount      <= '0;
         triggerPending <= 1'b0;
         wrEnable       <= 1'b0;
         wrAddress      <= '0;
         triggerAddress <= '0;
         triggerSource  <= '0;
         done           <= 1'b0;
         donePulse      <= 1'b0;
      end else begin
         history   <= sysTriggers;
         wrEnable  <= 1'b0;
         donePulse <= 1'b0;

         if (writeNow) begin
            wrEnable  <= 1'b1;
            wrAddress <= wrPtr;
            wrPtr     <= wrPtr + 1'b1;
         end

         if (sysAbort) begin
            state <= IDLE;
            done  <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (sysArm) begin
                     preCount       <= sysPretrigger;
                     postLength     <= postInit;
                     wrPtr          <= '0;
                     wrAddress      <= '0;
                     triggerAddress <= '0;
                     triggerSource  <= '0;
                     triggerPending <= 1'b0;
                     done           <= 1'b0;
                     state          <= (sysPretrigger == '0) ? ARMED : FILL;
                  end
               end
               FILL: begin
                  if (sampleValid) begin
                     preCount <= preCount - 1'b1;
                     if (preCount == ADDR_ONE) state <= ARMED;
                  end
               end
               ARMED: begin
                  if (events != '0) begin
                     triggerSource <= winner;
                     state         <= POST;
                     if (sampleValid) begin
                        triggerAddress <= wrPtr;
                        postCount      <= postLength - 1'b1;
                        triggerPending <= 1'b0;
                     end else begin
                        postCount      <= postLength;
                        triggerPending <= 1'b1;
                     end
                  end
               end
               POST: begin
                  // One idle cycle after the last post write lines donePulse up with wrEnable+1.
                  if (postCount == '0) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     donePulse <= 1'b1;
                  end else if (sampleValid) begin
                     postCount <= postCount - 1'b1;
                     if (triggerPending) begin
                        triggerAddress <= wrPtr;
                        triggerPending <= 1'b0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_acq_trigger_scheduler.sv
// Bench for acq_trigger_scheduler: acquisition-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_acq_trigger_scheduler;

   localparam int AW    = 5;
   localparam int SC    = 4;
   localparam int DEPTH = 1 << AW;

   localparam int PH_IDLE  = 0;
   localparam int PH_FILL  = 1;
   localparam int PH_ARMED = 2;
   localparam int PH_POST  = 3;
   localparam int PH_DONE  = 4;

   logic          sysClk = 1'b0;
   logic          sysReset;
   logic          sysArm;
   logic          sysAbort;
   logic [SC-1:0] sysTriggerEnables;
   logic [SC-1:0] sysTriggers;
   logic [AW-1:0] sysPretrigger;
   logic [AW-1:0] sysAcqLength;
   logic          sampleValid;
   logic          wrEnable;
   logic [AW-1:0] wrAddress;
   logic [AW-1:0] triggerAddress;
   logic [SC-1:0] triggerSource;
   logic          busy;
   logic          done;
   logic          donePulse;
   logic [2:0]    debugState;

   always #5 sysClk = ~sysClk;

   acq_trigger_scheduler #(.ADDR_WIDTH(AW), .SOURCE_COUNT(SC)) dut (
      .sysClk(sysClk), .sysReset(sysReset), .sysArm(sysArm), .sysAbort(sysAbort),
      .sysTriggerEnables(sysTriggerEnables), .sysTriggers(sysTriggers),
      .sysPretrigger(sysPretrigger), .sysAcqLength(sysAcqLength), .sampleValid(sampleValid),
      .wrEnable(wrEnable), .wrAddress(wrAddress), .triggerAddress(triggerAddress),
      .triggerSource(triggerSource), .busy(busy), .done(done), .donePulse(donePulse),
      .debugState(debugState)
   );

   int compared   = 0;
   int mismatched = 0;

   // Configuration applied on the next tick.
   logic [SC-1:0] cfgEn  = '0;
   logic [AW-1:0] cfgPre = '0;
   logic [AW-1:0] cfgLen = '0;
   logic          rstReq = 1'b1;

   // Reference model: acquisition phase plus sample counts since arm/trigger.
   int            mPhase;
   logic [SC-1:0] mHist;
   int            mWritesSinceArm, mPreTarget, mPostTarget, mPostWritten;
   bit            mTrigSampleTaken;
   logic          eWrEn, eDone, eDonePulse;
   logic [AW-1:0] eWrAddr, eTrigAddr;
   logic [SC-1:0] eTrigSrc;

   // Observed statistics for directed scenarios.
   int nWrites, nPulses, lastAddr, firstAddr;
   bit pulseAfterWrite, wrapSeen, prevWrEn;

   task automatic modelReset();
      mPhase = PH_IDLE; mHist = '1;
      mWritesSinceArm = 0; mPreTarget = 0; mPostTarget = 0; mPostWritten = 0;
      mTrigSampleTaken = 1'b1;
      eWrEn = 0; eDone = 0; eDonePulse = 0; eWrAddr = '0; eTrigAddr = '0; eTrigSrc = '0;
   endtask

   task automatic modelWrite();
      eWrEn   = 1'b1;
      eWrAddr = AW'(mWritesSinceArm % DEPTH);
      mWritesSinceArm++;
   endtask

   task automatic modelStep();
      logic [SC-1:0] ev;
      logic [SC-1:0] win;
      int diff;
      if (sysReset) begin
         modelReset();
         return;
      end
      ev    = sysTriggers & ~mHist & sysTriggerEnables;
      mHist = sysTriggers;
      win   = '0;
      for (int i = 0; i < SC; i++) if (ev[i] && win == '0) win[i] = 1'b1;
      eWrEn = 1'b0; eDonePulse = 1'b0;
      if (sysAbort) begin
         mPhase = PH_IDLE; eDone = 1'b0;
         return;
      end
      case (mPhase)
         PH_IDLE, PH_DONE: begin
            if (sysArm) begin
               diff = int'(sysAcqLength) - int'(sysPretrigger);
               mPreTarget  = int'(sysPretrigger);
               mPostTarget = (diff < 1) ? 1 : diff;
               mWritesSinceArm = 0; mPostWritten = 0;
               eWrAddr = '0; eTrigAddr = '0; eTrigSrc = '0; eDone = 1'b0;
               mPhase = (mPreTarget == 0) ? PH_ARMED : PH_FILL;
            end
         end
         PH_FILL: begin
            if (sampleValid) begin
               modelWrite();
               if (mWritesSinceArm == mPreTarget) mPhase = PH_ARMED;
            end
         end
         PH_ARMED: begin
            if (win != '0) begin
               eTrigSrc = win; mPhase = PH_POST; mPostWritten = 0; mTrigSampleTaken = 1'b0;
            end
            if (sampleValid) begin
               if (mPhase == PH_POST) begin
                  eTrigAddr = AW'(mWritesSinceArm % DEPTH);
                  mTrigSampleTaken = 1'b1; mPostWritten = 1;
               end
               modelWrite();
            end
         end
         PH_POST: begin
            if (mPostWritten == mPostTarget) begin
               mPhase = PH_DONE; eDone = 1'b1; eDonePulse = 1'b1;
            end else if (sampleValid) begin
               if (!mTrigSampleTaken) begin
                  eTrigAddr = AW'(mWritesSinceArm % DEPTH);
                  mTrigSampleTaken = 1'b1;
               end
               modelWrite();
               mPostWritten++;
            end
         end
         default: ;
      endcase
   endtask

   task automatic clearStats();
      nWrites = 0; nPulses = 0; lastAddr = -1; firstAddr = -1;
      pulseAfterWrite = 0; wrapSeen = 0; prevWrEn = 0;
   endtask

   task automatic checkOutputs();
      logic eBusy;
      eBusy = (mPhase == PH_FILL) || (mPhase == PH_ARMED) || (mPhase == PH_POST);
      compared++;
      if ({wrEnable, wrAddress, triggerAddress, triggerSource, busy, done, donePulse} !==
          {eWrEn, eWrAddr, eTrigAddr, eTrigSrc, eBusy, eDone, eDonePulse}) begin
         mismatched++;
         $display("FAIL cycle_outputs @%0t got wrEn=%0b wrAddr=%0d trigAddr=%0d trigSrc=%b busy=%0b done=%0b pulse=%0b want wrEn=%0b wrAddr=%0d trigAddr=%0d trigSrc=%b busy=%0b done=%0b pulse=%0b",
                  $time, wrEnable, wrAddress, triggerAddress, triggerSource, busy, done, donePulse,
                  eWrEn, eWrAddr, eTrigAddr, eTrigSrc, eBusy, eDone, eDonePulse);
      end
      if (wrEnable) begin
         if (firstAddr < 0) firstAddr = int'(wrAddress);
         if (lastAddr == DEPTH - 1 && wrAddress == '0) wrapSeen = 1;
         lastAddr = int'(wrAddress);
         nWrites++;
      end
      if (donePulse) begin
         nPulses++;
         pulseAfterWrite = prevWrEn;
      end
      prevWrEn = wrEnable;
   endtask

   task automatic checkLit(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("FAIL %s got %0d want %0d", name, actual, expected);
      end
   endtask

   // One clock: check the outputs of the previous edge, then drive the next inputs.
   task automatic tick(input bit arm, input bit abort, input bit valid, input logic [SC-1:0] trig);
      @(negedge sysClk);
      checkOutputs();
      sysReset = rstReq; sysTriggerEnables = cfgEn; sysPretrigger = cfgPre; sysAcqLength = cfgLen;
      sysArm = arm; sysAbort = abort; sampleValid = valid; sysTriggers = trig;
      modelStep();
   endtask

   task automatic asyncResetCheck();
      @(negedge sysClk);
      checkOutputs();
      rstReq = 1'b1; sysReset = 1'b1;
      sysArm = 0; sysAbort = 0; sampleValid = 0;
      #1;
      checkLit("async_reset_outputs",
               int'({wrEnable, wrAddress, triggerAddress, triggerSource, busy, done, donePulse}), 0);
      modelStep();
   endtask

   logic [SC-1:0] rTrig;
   logic [SC-1:0] flip;

   initial begin
      sysReset = 1'b1; sysArm = 0; sysAbort = 0; sysTriggerEnables = '0; sysTriggers = '0;
      sysPretrigger = '0; sysAcqLength = '0; sampleValid = 0;
      modelReset();
      clearStats();
      repeat (3) tick(0, 0, 0, '0);
      checkLit("reset_outputs",
               int'({wrEnable, wrAddress, triggerAddress, triggerSource, busy, done, donePulse}), 0);
      rstReq = 1'b0;

      // pre=4 len=10, source 1, trigger on the sample written at address 20.
      cfgEn = 4'b0010; cfgPre = 5'd4; cfgLen = 5'd10;
      clearStats();
      tick(1, 0, 1, 4'b0000);
      for (int c = 1; c <= 20; c++) tick(0, 0, 1, 4'b0000);
      for (int c = 21; c <= 32; c++) tick(0, 0, 1, 4'b0010);
      checkLit("t1_write_count", nWrites, 26);
      checkLit("t1_last_addr", lastAddr, 25);
      checkLit("t1_trigger_addr", int'(triggerAddress), 20);
      checkLit("t1_trigger_src", int'(triggerSource), 2);
      checkLit("t1_done_pulses", nPulses, 1);
      checkLit("t1_pulse_after_last_write", int'(pulseAfterWrite), 1);
      checkLit("t1_done_level", int'(done), 1);

      // Sources 0 and 2 rise together: source 0 wins.
      cfgEn = 4'b0101; cfgPre = 5'd2; cfgLen = 5'd5;
      clearStats();
      tick(1, 0, 1, 4'b0000);
      for (int c = 1; c <= 4; c++) tick(0, 0, 1, 4'b0000);
      for (int c = 5; c <= 12; c++) tick(0, 0, 1, 4'b0101);
      checkLit("t2_trigger_src", int'(triggerSource), 1);
      checkLit("t2_trigger_addr", int'(triggerAddress), 4);
      checkLit("t2_write_count", nWrites, 7);

      // Trigger pulse during FILL is discarded; recording wraps circularly.
      cfgEn = 4'b0001; cfgPre = 5'd8; cfgLen = 5'd20;
      clearStats();
      tick(1, 0, 1, 4'b0000);
      for (int c = 1; c <= 50; c++) tick(0, 0, 1, (c == 3) ? 4'b0001 : 4'b0000);
      tick(0, 0, 1, 4'b0000);
      checkLit("t3_busy", int'(busy), 1);
      checkLit("t3_not_done", int'(done), 0);
      checkLit("t3_no_trigger_src", int'(triggerSource), 0);
      checkLit("t3_wrapped", int'(wrapSeen), 1);
      tick(0, 1, 0, 4'b0000);
      tick(0, 0, 0, 4'b0000);
      checkLit("t3_abort_idle", int'(busy), 0);

      // pre=0 len=1 with trigger on the first sample.
      cfgEn = 4'b0001; cfgPre = 5'd0; cfgLen = 5'd1;
      clearStats();
      tick(1, 0, 0, 4'b0000);
      tick(0, 0, 1, 4'b0001);
      repeat (4) tick(0, 0, 0, 4'b0001);
      checkLit("t4_write_count", nWrites, 1);
      checkLit("t4_addr", lastAddr, 0);
      checkLit("t4_trigger_addr", int'(triggerAddress), 0);
      checkLit("t4_trigger_src", int'(triggerSource), 1);
      checkLit("t4_pulse_after_write", int'(pulseAfterWrite), 1);

      // Abort with simultaneous arm during POST.
      cfgEn = 4'b0001; cfgPre = 5'd2; cfgLen = 5'd20;
      clearStats();
      tick(1, 0, 1, 4'b0000);
      for (int c = 1; c <= 4; c++) tick(0, 0, 1, 4'b0000);
      for (int c = 5; c <= 7; c++) tick(0, 0, 1, 4'b0001);
      tick(1, 1, 1, 4'b0001);
      repeat (3) tick(0, 0, 0, 4'b0001);
      checkLit("t5_no_pulse", nPulses, 0);
      checkLit("t5_busy", int'(busy), 0);
      checkLit("t5_done", int'(done), 0);
      checkLit("t5_trigger_addr_held", int'(triggerAddress), 4);
      checkLit("t5_trigger_src_held", int'(triggerSource), 1);
      clearStats();
      tick(1, 0, 0, 4'b0000);
      repeat (4) tick(0, 0, 1, 4'b0000);
      checkLit("t5_rearm_first_addr", firstAddr, 0);
      tick(0, 0, 1, 4'b0001);
      repeat (2) tick(0, 0, 1, 4'b0001);
      asyncResetCheck();

      // Trigger held high through reset release gives no event.
      tick(0, 0, 0, 4'b0010);
      tick(0, 0, 0, 4'b0010);
      rstReq = 1'b0;
      cfgEn = 4'b0010; cfgPre = 5'd0; cfgLen = 5'd3;
      tick(1, 0, 0, 4'b0010);
      repeat (5) tick(0, 0, 1, 4'b0010);
      tick(0, 0, 1, 4'b0000);
      checkLit("t6_held_no_event", int'(triggerSource), 0);
      checkLit("t6_still_busy", int'(busy), 1);
      tick(0, 0, 1, 4'b0010);
      repeat (6) tick(0, 0, 1, 4'b0010);
      checkLit("t6_trigger_src", int'(triggerSource), 2);
      checkLit("t6_trigger_addr", int'(triggerAddress), 6);
      checkLit("t6_done", int'(done), 1);

      // Randomized traffic, including config changes mid-acquisition.
      rTrig = '0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 49) == 0) cfgEn = SC'($urandom_range(0, (1 << SC) - 1));
         if ($urandom_range(0, 19) == 0) begin
            cfgPre = AW'($urandom_range(0, DEPTH - 1));
            cfgLen = AW'($urandom_range(1, DEPTH - 1));
         end
         rstReq = ($urandom_range(0, 1499) == 0);
         flip = '0;
         for (int b = 0; b < SC; b++) flip[b] = ($urandom_range(0, 7) == 0);
         rTrig = rTrig ^ flip;
         tick($urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0,
              $urandom_range(0, 3) != 0, rTrig);
      end
      rstReq = 1'b0;
      tick(0, 0, 0, rTrig);
      tick(0, 0, 0, rTrig);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
